// File: rtl/wb_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_arbiter_if : FU result / write-back port bundle for wb_arbiter      |
// | Revision      : 1.0                                                    |
// +------------------------------------------------------------------------+

package wb_arbiter_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } fu_output_t;
endpackage

interface wb_arbiter_if #(
  parameter int NR_REQ   = 4,
  parameter int NR_PORTS = 2
);
  import wb_arbiter_pkg::*;

  fu_output_t [NR_REQ-1:0]   req_i;
  logic       [NR_REQ-1:0]   req_valid_i;
  logic       [NR_REQ-1:0]   req_ready_o;
  fu_output_t [NR_PORTS-1:0] wb_o;
  logic       [NR_PORTS-1:0] wb_valid_o;
  logic                      flush_i;

  modport slave (
    input  req_i, req_valid_i, flush_i,
    output req_ready_o, wb_o, wb_valid_o
  );

  modport master (
    output req_i, req_valid_i, flush_i,
    input  req_ready_o, wb_o, wb_valid_o
  );
endinterface

`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_arbiter : round-robin sharing of NR_PORTS write-back ports among    |
// |              NR_REQ FU result streams, one holding entry per requester |
// | Revision   : 1.0                                                       |
// +------------------------------------------------------------------------+

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NR_REQ   = 4,
  parameter int NR_PORTS = 2
) (
  input  logic         clk,
  input  logic         rstn,
  wb_arbiter_if.slave  bus
);

  localparam int c_PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic       [NR_REQ-1:0]   r_hold_valid;
  fu_output_t [NR_REQ-1:0]   r_hold_data;
  logic       [c_PTR_W-1:0]  r_rr_ptr;

  logic       [NR_REQ-1:0]   w_fresh;
  logic       [NR_REQ-1:0]   w_elig;
  logic       [NR_REQ-1:0]   w_grant;
  fu_output_t [NR_REQ-1:0]   w_payload;
  fu_output_t [NR_PORTS-1:0] w_wb;
  logic       [NR_PORTS-1:0] w_wbv;
  logic       [c_PTR_W-1:0]  w_rr_next;
  logic                      w_any_grant;
  int                        w_off  [NR_REQ];
  int                        w_rank [NR_REQ];
  int                        w_best_off;

  assign w_fresh = bus.req_valid_i & ~r_hold_valid;
  // Reset and flush both suppress every grant, so outputs stay quiet.
  assign w_elig  = (r_hold_valid | w_fresh) & {NR_REQ{rstn & ~bus.flush_i}};

  always_comb begin
    w_grant     = '0;
    w_payload   = '0;
    w_wb        = '0;
    w_wbv       = '0;
    w_rr_next   = r_rr_ptr;
    w_any_grant = 1'b0;
    w_best_off  = -1;

    // Distance of each requester from the pointer in scan order.
    for (int i = 0; i < NR_REQ; i++) begin
      w_off[i] = i - int'(r_rr_ptr);
      if (w_off[i] < 0) w_off[i] = w_off[i] + NR_REQ;
      w_payload[i] = r_hold_valid[i] ? r_hold_data[i] : bus.req_i[i];
    end

    // Rank = number of eligible requesters ahead in scan order.
    for (int i = 0; i < NR_REQ; i++) begin
      w_rank[i] = 0;
      for (int m = 0; m < NR_REQ; m++) begin
        if (w_elig[m] && (w_off[m] < w_off[i])) w_rank[i] = w_rank[i] + 1;
      end
      w_grant[i] = w_elig[i] && (w_rank[i] < NR_PORTS);
    end

    for (int p = 0; p < NR_PORTS; p++) begin
      for (int i = 0; i < NR_REQ; i++) begin
        if (w_grant[i] && (w_rank[i] == p)) begin
          w_wb[p]  = w_payload[i];
          w_wbv[p] = 1'b1;
        end
      end
    end

    for (int i = 0; i < NR_REQ; i++) begin
      if (w_grant[i] && (w_off[i] > w_best_off)) begin
        w_best_off  = w_off[i];
        w_rr_next   = c_PTR_W'((i + 1) % NR_REQ);
        w_any_grant = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold_valid <= '0;
      r_hold_data  <= '0;
      r_rr_ptr     <= '0;
    end else if (bus.flush_i) begin
      r_hold_valid <= '0;
    end else begin
      for (int i = 0; i < NR_REQ; i++) begin
        if (w_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end else if (w_fresh[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_data[i]  <= bus.req_i[i];
        end
      end
      if (w_any_grant) r_rr_ptr <= w_rr_next;
    end
  end

  assign bus.req_ready_o = ~r_hold_valid;
  assign bus.wb_o        = w_wb;
  assign bus.wb_valid_o  = w_wbv;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_wb_arbiter : vector table + scoreboard bench for wb_arbiter (4x2)   |
// | Revision      : 1.0                                                    |
// +------------------------------------------------------------------------+

module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NR_REQ   = 4;
  localparam int NR_PORTS = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  wb_arbiter_if #(.NR_REQ(NR_REQ), .NR_PORTS(NR_PORTS)) bus ();

  wb_arbiter #(.NR_REQ(NR_REQ), .NR_PORTS(NR_PORTS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ids: nibble i is requester i's id; eids: nibble p is the id expected on port p
  typedef struct packed {
    logic [3:0]  valid;
    logic [15:0] ids;
    logic        flush;
    logic [3:0]  ready;
    logic [1:0]  wbv;
    logic [7:0]  eids;
  } vec_t;

  typedef struct packed {
    logic [3:0]       ready;
    logic [1:0]       wbv;
    fu_output_t [1:0] wb;
  } exp_t;

  exp_t sb [$];
  vec_t vecs [14];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic fu_output_t mk(input logic [3:0] id);
    fu_output_t f;
    f.id   = id;
    f.data = {28'hA5A5C3C, id};
    return f;
  endfunction

  function automatic vec_t mkv(input logic [3:0] v, input logic [15:0] ids, input logic fl,
                               input logic [3:0] rdy, input logic [1:0] wbv, input logic [7:0] e);
    vec_t r;
    r.valid = v;  r.ids = ids;  r.flush = fl;
    r.ready = rdy; r.wbv = wbv; r.eids  = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] ids, input logic fl);
    bus.req_valid_i = v;
    for (int i = 0; i < NR_REQ; i++) bus.req_i[i] = mk(ids[4*i +: 4]);
    bus.flush_i = fl;
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " ready"}, 64'(bus.req_ready_o), 64'(e.ready));
      chk({tag, " wb_valid"}, 64'(bus.wb_valid_o), 64'(e.wbv));
      chk({tag, " wb0"}, 64'(bus.wb_o[0]), 64'(e.wb[0]));
      chk({tag, " wb1"}, 64'(bus.wb_o[1]), 64'(e.wb[1]));
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v.valid, v.ids, v.flush);
    e.ready = v.ready;
    e.wbv   = v.wbv;
    for (int p = 0; p < NR_PORTS; p++) e.wb[p] = v.wbv[p] ? mk(v.eids[4*p +: 4]) : '0;
    sb.push_back(e);
    @(negedge clk);
    check_sb(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [4];
    int last [4];
    int maxgap [4];
    int r;

    vecs[0]  = mkv(4'b0000, 16'h0000, 1'b0, 4'b1111, 2'b00, 8'h00);
    vecs[1]  = mkv(4'b1111, 16'h4321, 1'b0, 4'b1111, 2'b11, 8'h21);
    vecs[2]  = mkv(4'b1111, 16'hFE65, 1'b0, 4'b0011, 2'b11, 8'h43);
    vecs[3]  = mkv(4'b0001, 16'h000D, 1'b0, 4'b1100, 2'b11, 8'h65);
    vecs[4]  = mkv(4'b0100, 16'h0500, 1'b0, 4'b1111, 2'b01, 8'h05);
    vecs[5]  = mkv(4'b1111, 16'h4321, 1'b0, 4'b1111, 2'b11, 8'h14);
    vecs[6]  = mkv(4'b0000, 16'h0000, 1'b0, 4'b1001, 2'b11, 8'h32);
    vecs[7]  = mkv(4'b0000, 16'h0000, 1'b0, 4'b1111, 2'b00, 8'h00);
    vecs[8]  = mkv(4'b1111, 16'h4321, 1'b0, 4'b1111, 2'b11, 8'h14);
    vecs[9]  = mkv(4'b0001, 16'h0009, 1'b1, 4'b1001, 2'b00, 8'h00);
    vecs[10] = mkv(4'b0000, 16'h0000, 1'b0, 4'b1111, 2'b00, 8'h00);
    vecs[11] = mkv(4'b1111, 16'hBA98, 1'b0, 4'b1111, 2'b11, 8'hA9);
    vecs[12] = mkv(4'b0000, 16'h0000, 1'b0, 4'b0110, 2'b11, 8'h8B);
    vecs[13] = mkv(4'b0000, 16'h0000, 1'b0, 4'b1111, 2'b00, 8'h00);

    drive(4'b0000, 16'h0000, 1'b0);
    #2;
    chk("reset ready", 64'(bus.req_ready_o), 64'hF);
    chk("reset wb_valid", 64'(bus.wb_valid_o), 64'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int n = 0; n < 14; n++) apply(vecs[n], $sformatf("v%0d", n));

    // Continuous demand from every requester; rr_ptr starts at 1 here.
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0; last[i] = -1; maxgap[i] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 drive(4'b1111, 16'h4321, 1'b0);
      @(negedge clk);
      for (int p = 0; p < NR_PORTS; p++) begin
        if (bus.wb_valid_o[p]) begin
          r = int'(bus.wb_o[p].id) - 1;
          if (r >= 0 && r < 4) begin
            cnt[r]++;
            if (last[r] >= 0 && (c - last[r]) > maxgap[r]) maxgap[r] = c - last[r];
            last[r] = c;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fair count r%0d", i), 64'(cnt[i]), 64'd4);
      chk($sformatf("fair gap r%0d", i), 64'(maxgap[i] <= 2 && maxgap[i] > 0), 64'd1);
    end
    apply(mkv(4'b0000, 16'h0000, 1'b0, 4'b1001, 2'b11, 8'h32), "drain");
    apply(mkv(4'b0000, 16'h0000, 1'b0, 4'b1111, 2'b00, 8'h00), "drained");

    // Asynchronous reset while two entries are held.
    apply(mkv(4'b1111, 16'h4321, 1'b0, 4'b1111, 2'b11, 8'h14), "prehold");
    @(posedge clk);
    #1 drive(4'b1111, 16'h8765, 1'b0);
    #1 chk("hold ready", 64'(bus.req_ready_o), 64'h9);
    #1 rstn = 1'b0;
    #1;
    chk("async rst ready", 64'(bus.req_ready_o), 64'hF);
    chk("async rst wb_valid", 64'(bus.wb_valid_o), 64'h0);
    chk("async rst wb", 64'(bus.wb_o), 64'h0);
    @(posedge clk);
    #1 drive(4'b0000, 16'h0000, 1'b0);
    rstn = 1'b1;
    apply(mkv(4'b1111, 16'h4321, 1'b0, 4'b1111, 2'b11, 8'h21), "post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
